// File: rtl/usb_pkg.sv
// Shared USB receive definitions: PID nibbles, rx_packet codes, framing
// constants and the receive controller state enum.
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam logic [2:0] PKT_NONE  = 3'd0;
  localparam logic [2:0] PKT_OUT   = 3'd1;
  localparam logic [2:0] PKT_IN    = 3'd2;
  localparam logic [2:0] PKT_DATA0 = 3'd3;
  localparam logic [2:0] PKT_DATA1 = 3'd4;
  localparam logic [2:0] PKT_ACK   = 3'd5;
  localparam logic [2:0] PKT_NAK   = 3'd6;
  localparam logic [2:0] PKT_STALL = 3'd7;

  localparam logic [7:0]  SYNC_BYTE     = 8'h80;
  localparam logic [15:0] CRC16_RESIDUE = 16'h800D;
  localparam logic [15:0] CRC16_POLY    = 16'h8005;

  typedef enum logic [2:0] {
    IDLE, SYNC_WAIT, PID_WAIT, TOKEN, HS_EOP, DATA, EOP_WAIT, ERR
  } rx_state_t;

endpackage

// File: rtl/usb_rx_controller_if.sv
// Bus bundle between the bit-level receive path / FIFO / slave and the
// packet receive controller. The controller connects through the slave
// modport; the surrounding logic (or a bench) drives through master.
interface usb_rx_controller_if;
  logic       d_edge;
  logic       byte_received;
  logic [7:0] rcv_data;
  logic       eop;
  logic [6:0] buffer_occupancy;
  logic       rcving;
  logic       flush;
  logic       w_enable;
  logic [7:0] w_data;
  logic [2:0] rx_packet;
  logic       rx_data_ready;
  logic       rx_error;

  modport master (
    output d_edge, byte_received, rcv_data, eop, buffer_occupancy,
    input  rcving, flush, w_enable, w_data, rx_packet, rx_data_ready, rx_error
  );

  modport slave (
    input  d_edge, byte_received, rcv_data, eop, buffer_occupancy,
    output rcving, flush, w_enable, w_data, rx_packet, rx_data_ready, rx_error
  );
endinterface

// File: rtl/usb_rx_crc16.sv
// Bytewise USB CRC16 checker (x^16+x^15+x^2+1, LSB first, init FFFF).
// Feeding the payload plus its transmitted CRC leaves the fixed residue.
module usb_rx_crc16
  import usb_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       clear,
  input  logic       byte_valid,
  input  logic [7:0] data_in,
  output logic       crc_ok
);

  logic [15:0] crc_q, crc_d;

  // Fold one byte into the running remainder, first bus bit first
  always_comb begin
    crc_d = crc_q;
    if (clear) begin
      crc_d = 16'hFFFF;
    end else if (byte_valid) begin
      for (int i = 0; i < 8; i++) begin
        if (data_in[i] ^ crc_d[15]) crc_d = {crc_d[14:0], 1'b0} ^ CRC16_POLY;
        else                        crc_d = {crc_d[14:0], 1'b0};
      end
    end
  end

  // Remainder register
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) crc_q <= 16'hFFFF;
    else        crc_q <= crc_d;
  end

  assign crc_ok = (crc_q == CRC16_RESIDUE);

endmodule

// File: rtl/usb_rx_controller.sv
// Packet-level USB full-speed receive controller: frames SYNC/PID/payload/
// CRC/EOP, writes DATA payload bytes (CRC stripped) into the endpoint FIFO
// and reports packet type, data-ready and error status.
// Build option: define USB_RX_CRC_CHECK_EN to instantiate the CRC16 checker;
// without it CRC mismatches are not reported.
module usb_rx_controller
  import usb_pkg::*;
#(
  parameter int MAX_PAYLOAD = 64,
  parameter int FIFO_DEPTH  = 64
) (
  input logic             clk,
  input logic             n_rst,
  usb_rx_controller_if.slave bus
);

  localparam int CNT_W = $clog2(MAX_PAYLOAD + 4);
  localparam logic [CNT_W-1:0] MAX_TOTAL = CNT_W'(MAX_PAYLOAD + 2);
  localparam logic [CNT_W-1:0] TWO       = CNT_W'(2);
  localparam logic [6:0]       FIFO_FULL = 7'(FIFO_DEPTH);

  rx_state_t        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [7:0]       h0_q, h0_d, h1_q, h1_d;
  logic [2:0]       pkt_q, pkt_d;
  logic             rcving_q, rcving_d;
  logic             flush_q, flush_d;
  logic             w_enable_q, w_enable_d;
  logic [7:0]       w_data_q, w_data_d;
  logic [2:0]       rx_packet_q, rx_packet_d;
  logic             rx_data_ready_q, rx_data_ready_d;
  logic             rx_error_q, rx_error_d;
  logic             err_eop, data_done, write_h1;
  logic             crc_ok;

`ifdef USB_RX_CRC_CHECK_EN
  logic crc_clear, crc_feed;
  assign crc_clear = (state_q == PID_WAIT) && (state_d == DATA);
  assign crc_feed  = (state_q == DATA) && bus.byte_received && !bus.eop;

  usb_rx_crc16 u_crc16 (
    .clk        (clk),
    .n_rst      (n_rst),
    .clear      (crc_clear),
    .byte_valid (crc_feed),
    .data_in    (bus.rcv_data),
    .crc_ok     (crc_ok)
  );
`else
  assign crc_ok = 1'b1;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q         <= IDLE;
      count_q         <= '0;
      h0_q            <= '0;
      h1_q            <= '0;
      pkt_q           <= PKT_NONE;
      rcving_q        <= 1'b0;
      flush_q         <= 1'b0;
      w_enable_q      <= 1'b0;
      w_data_q        <= '0;
      rx_packet_q     <= PKT_NONE;
      rx_data_ready_q <= 1'b0;
      rx_error_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      h0_q            <= h0_d;
      h1_q            <= h1_d;
      pkt_q           <= pkt_d;
      rcving_q        <= rcving_d;
      flush_q         <= flush_d;
      w_enable_q      <= w_enable_d;
      w_data_q        <= w_data_d;
      rx_packet_q     <= rx_packet_d;
      rx_data_ready_q <= rx_data_ready_d;
      rx_error_q      <= rx_error_d;
    end
  end

  // Next-state: packet framing; eop always wins over a same-cycle byte
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    h0_d      = h0_q;
    h1_d      = h1_q;
    pkt_d     = pkt_q;
    err_eop   = 1'b0;
    data_done = 1'b0;
    write_h1  = 1'b0;
    unique case (state_q)
      IDLE: if (bus.d_edge) state_d = SYNC_WAIT;
      SYNC_WAIT: begin
        if (bus.eop) begin
          state_d = EOP_WAIT;
          err_eop = 1'b1;
        end else if (bus.byte_received) begin
          state_d = (bus.rcv_data == SYNC_BYTE) ? PID_WAIT : ERR;
        end
      end
      PID_WAIT: begin
        if (bus.eop) begin
          state_d = EOP_WAIT;
          err_eop = 1'b1;
        end else if (bus.byte_received) begin
          count_d = '0;
          if (bus.rcv_data[7:4] != ~bus.rcv_data[3:0]) begin
            state_d = ERR;
          end else begin
            case (bus.rcv_data[3:0])
              PID_OUT:   begin state_d = TOKEN;  pkt_d = PKT_OUT;   end
              PID_IN:    begin state_d = TOKEN;  pkt_d = PKT_IN;    end
              PID_DATA0: begin state_d = DATA;   pkt_d = PKT_DATA0; end
              PID_DATA1: begin state_d = DATA;   pkt_d = PKT_DATA1; end
              PID_ACK:   begin state_d = HS_EOP; pkt_d = PKT_ACK;   end
              PID_NAK:   begin state_d = HS_EOP; pkt_d = PKT_NAK;   end
              PID_STALL: begin state_d = HS_EOP; pkt_d = PKT_STALL; end
              default:   state_d = ERR;
            endcase
          end
        end
      end
      TOKEN: begin
        if (bus.eop) begin
          state_d = EOP_WAIT;
          err_eop = (count_q != TWO);
        end else if (bus.byte_received) begin
          if (count_q == TWO) state_d = ERR;
          else                count_d = count_q + 1'b1;
        end
      end
      HS_EOP: begin
        if (bus.eop)                state_d = EOP_WAIT;
        else if (bus.byte_received) state_d = ERR;
      end
      DATA: begin
        if (bus.eop) begin
          state_d = EOP_WAIT;
          if (count_q < TWO || !crc_ok) err_eop   = 1'b1;
          else                          data_done = 1'b1;
        end else if (bus.byte_received) begin
          if (count_q == MAX_TOTAL) begin
            state_d = ERR;
          end else if (count_q >= TWO && bus.buffer_occupancy == FIFO_FULL) begin
            state_d = ERR;
          end else begin
            count_d  = count_q + 1'b1;
            h1_d     = h0_q;
            h0_d     = bus.rcv_data;
            write_h1 = (count_q >= TWO);
          end
        end
      end
      EOP_WAIT: if (!bus.eop) state_d = IDLE;
      ERR:      if (bus.eop)  state_d = EOP_WAIT;
      default:  state_d = IDLE;
    endcase
  end

  // Outputs: registered status and FIFO strobes derived from the transition
  always_comb begin
    rcving_d        = rcving_q;
    flush_d         = 1'b0;
    w_enable_d      = 1'b0;
    w_data_d        = w_data_q;
    rx_packet_d     = rx_packet_q;
    rx_data_ready_d = rx_data_ready_q;
    rx_error_d      = rx_error_q;
    if (state_q == IDLE && bus.d_edge) begin
      rcving_d        = 1'b1;
      rx_packet_d     = PKT_NONE;
      rx_data_ready_d = 1'b0;
      rx_error_d      = 1'b0;
    end
    if (state_q == EOP_WAIT && !bus.eop) rcving_d = 1'b0;
    if (state_q == PID_WAIT && state_d == DATA) flush_d = 1'b1;
    if (write_h1) begin
      w_enable_d = 1'b1;
      w_data_d   = h1_q;
    end
    if (state_d == ERR || err_eop) rx_error_d = 1'b1;
    if (data_done) rx_data_ready_d = 1'b1;
    if ((state_q == TOKEN || state_q == HS_EOP || state_q == DATA) &&
        state_d == EOP_WAIT && !err_eop) begin
      rx_packet_d = pkt_q;
    end
  end

  assign bus.rcving        = rcving_q;
  assign bus.flush         = flush_q;
  assign bus.w_enable      = w_enable_q;
  assign bus.w_data        = w_data_q;
  assign bus.rx_packet     = rx_packet_q;
  assign bus.rx_data_ready = rx_data_ready_q;
  assign bus.rx_error      = rx_error_q;

endmodule
